instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Program store and fetch stage directly upstream of the datapath. It accepts an
//  8-bit program through a valid/ready load port and then serves instruction = mem[PC]
//  one cycle after the datapath presents PC. It also drives run, which enables the datapath.
// PARAMETERS
//  DEPTH      64     program words stored; legal range 1..255
//  NOP_INSTR  8'h00  word driven when idle, loading, or PC >= prog_len
// PORTS
//  _CLK         in   1  single clock, rising edge
//  _RESET       in   1  synchronous, active-low reset
//  load_start   in   1  pulse: enter LOAD and clear the write pointer
//  load_data    in   8  program word
//  load_valid   in   1  load_data is valid this cycle
//  load_ready   out  1  unit accepts a word this cycle
//  load_done    in   1  pulse: end of load, enter RUN
//  PC           in   8  program counter from the datapath
//  instruction  out  8  registered fetch result to the datapath
//  run          out  1  datapath enable (high only in RUN)
//  prog_len     out  8  number of words accepted in the last load
//  checksum     out  8  present only with LOAD_CHECKSUM_EN
// BEHAVIOUR
//  - Reset (_RESET==0 at a rising edge):
//    - state=IDLE, wptr=0, prog_len=0, instruction=NOP_INSTR, load_ready=0, run=0.
//    - Memory contents are not cleared.
//  - IDLE:
//    - load_start -> LOAD.
//    - load_done is ignored. Outputs hold their reset values.
//  - LOAD:
//    - load_ready=1 iff wptr<DEPTH (combinational from registered wptr).
//    - Beat = load_valid&&load_ready: mem[wptr]<=load_data, wptr++, prog_len<=wptr+1.
//    - wptr==DEPTH (full): load_ready=0; load_valid is ignored with no wrap and no overwrite.
//    - load_done -> RUN next cycle. A beat in the same cycle is written first.
//    - load_start in LOAD restarts the load: wptr=0, prog_len=0.
//    - instruction=NOP_INSTR and run=0 throughout.
//  - RUN:
//    - run=1.
//    - Each edge: instruction <= (PC<prog_len) ? mem[PC[ADDR_W-1:0]] : NOP_INSTR.
//    - Latency is exactly 1 cycle from PC to instruction. The full 8-bit PC is compared.
//    - load_start -> LOAD. run=0 and instruction=NOP_INSTR from the next edge.
//  - Simultaneous load_start and load_done: load_start wins.
//  - Any state: reset wins over every input. A partial load is lost (prog_len=0).
//  - prog_len==0 in RUN: every fetch returns NOP_INSTR.
//  - ADDR_W = $clog2(DEPTH); minimum 1.
// CONFIGURATION
//  - LOAD_CHECKSUM_EN defined:
//    - checksum port exists: 8-bit modulo-256 sum of the words accepted in the current
//      load, cleared by reset and by load_start, updated on each beat.
//  - LOAD_CHECKSUM_EN undefined: no checksum port and no adder.
// STRUCTURE
//  - Shared package/header ifu_defs: state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2)
//    and the default NOP_INSTR.
//  - Sub-module instr_ram: DEPTH x 8 with synchronous write, synchronous read port.
//  - The fetch register is the RAM read register; the PC<prog_len mux sits after it
//    using a registered compare flag.
// TESTING
//  1. Reset: hold _RESET=0 for 2 edges with load_start=1 -> state IDLE, run=0,
//     instruction=8'h00, prog_len=0.
//  2. Load, then run:
//     - Load 8'h71,4D,74,B7,05 with load_valid high for 5 cycles, then load_done.
//     - prog_len=5, run=1. PC=0..4 -> instruction 71,4D,74,B7,05 one cycle after each PC.
//  3. Out of range: after test 2, PC=5 and PC=8'hFF -> instruction=8'h00. run stays 1.
//  4. Full (DEPTH=4):
//     - Offer 6 words -> load_ready drops after 4, prog_len=4.
//     - Words 5 and 6 are not stored; mem[0] is unchanged.
//  5. Simultaneous events:
//     - load_start and load_done in the same cycle during RUN -> LOAD (run=0, wptr=0).
//     - A beat and load_done together -> the word is stored and prog_len includes it.
//  6. LOAD_CHECKSUM_EN: load 8'hFF,8'h02 -> checksum=8'h01.
//     A following load_start clears it to 8'h00.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding, default NOP word
// and address-width helper.
package ifu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ifu_state_e;

  localparam logic [7:0] NOP_DEFAULT = 8'h00;

  // Address width for a given depth, never narrower than one bit.
  function automatic int addr_w_of(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_ram.sv
// Program store for the fetch unit: single write port, registered read port.
module instr_ram #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata_p1
);

  // Sized to the full address space so every raddr value is a legal index.
  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_p1 <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program store and fetch stage: valid/ready program load, then instruction = mem[PC] one
// cycle after PC. Optional feature macro: LOAD_CHECKSUM_EN (adds the checksum output).
module instr_fetch_unit
  import ifu_defs::*;
#(
  parameter int         DEPTH     = 64,
  parameter logic [7:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic       _CLK,
  input  logic       _RESET,
  input  logic       load_start,
  input  logic [7:0] load_data,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic       load_done,
  input  logic [7:0] PC,
  output logic [7:0] instruction,
  output logic       run,
  output logic [7:0] prog_len
`ifdef LOAD_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  localparam int         ADDR_W   = addr_w_of(DEPTH);
  localparam logic [7:0] DEPTH_W8 = 8'(DEPTH);

  ifu_state_e state_q, state_d;
  logic [7:0] wptr_q;
  logic       beat;
  logic       vld_p1;
  logic       vld_p0;
  logic [7:0] rdata_p1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = LOAD;
      LOAD: begin
        if (load_start)     state_d = LOAD;
        else if (load_done) state_d = RUN;
      end
      RUN:     if (load_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  // A restart takes priority over a word offered in the same cycle; that word is dropped.
  assign load_ready = (state_q == LOAD) && (wptr_q < DEPTH_W8);
  assign beat       = load_ready && load_valid && !load_start;
  assign run        = (state_q == RUN);

  // Compare flag travels alongside the RAM read so the NOP mux sits after the read register.
  assign vld_p0 = (state_q == RUN) && !load_start && (PC < prog_len);

  always_ff @(posedge _CLK) begin
    if (!_RESET) begin
      state_q  <= IDLE;
      wptr_q   <= 8'd0;
      prog_len <= 8'd0;
      vld_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= vld_p0;
      if (load_start) begin
        wptr_q   <= 8'd0;
        prog_len <= 8'd0;
      end else if (beat) begin
        wptr_q   <= wptr_q + 8'd1;
        prog_len <= wptr_q + 8'd1;
      end
    end
  end

`ifdef LOAD_CHECKSUM_EN
  always_ff @(posedge _CLK) begin
    if (!_RESET) begin
      checksum <= 8'd0;
    end else if (load_start) begin
      checksum <= 8'd0;
    end else if (beat) begin
      checksum <= checksum + load_data;
    end
  end
`endif

  instr_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk      (_CLK),
    .we       (beat),
    .waddr    (wptr_q[ADDR_W-1:0]),
    .wdata    (load_data),
    .raddr    (PC[ADDR_W-1:0]),
    .rdata_p1 (rdata_p1)
  );

  // ---- stage p1: fetch result ----
  assign instruction = vld_p1 ? rdata_p1 : NOP_INSTR;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a default-depth instance and a DEPTH=4 instance.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start, load_valid, load_done;
  logic [7:0] load_data, pc;
  logic       load_ready, run;
  logic [7:0] instruction, prog_len;
  logic       load_start4, load_valid4, load_done4;
  logic [7:0] load_data4, pc4;
  logic       load_ready4, run4;
  logic [7:0] instruction4, prog_len4;
`ifdef LOAD_CHECKSUM_EN
  logic [7:0] checksum, checksum4;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(64)) dut (
    ._CLK(clk), ._RESET(rst_n),
    .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .load_done(load_done), .PC(pc),
    .instruction(instruction), .run(run), .prog_len(prog_len)
`ifdef LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  instr_fetch_unit #(.DEPTH(4)) dut4 (
    ._CLK(clk), ._RESET(rst_n),
    .load_start(load_start4), .load_data(load_data4), .load_valid(load_valid4),
    .load_ready(load_ready4), .load_done(load_done4), .PC(pc4),
    .instruction(instruction4), .run(run4), .prog_len(prog_len4)
`ifdef LOAD_CHECKSUM_EN
    , .checksum(checksum4)
`endif
  );

  typedef struct {
    logic [7:0] pc;
    logic [7:0] instr;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'd0,   8'h71};
    vecs[1] = '{8'd1,   8'h4D};
    vecs[2] = '{8'd2,   8'h74};
    vecs[3] = '{8'd3,   8'hB7};
    vecs[4] = '{8'd4,   8'h05};
    vecs[5] = '{8'd5,   8'h00};
    vecs[6] = '{8'hFF,  8'h00};
    vecs[7] = '{8'd3,   8'hB7};

    rst_n = 1'b0; load_start = 1'b1; load_valid = 1'b0; load_done = 1'b0;
    load_data = 8'h00; pc = 8'h00;
    load_start4 = 1'b0; load_valid4 = 1'b0; load_done4 = 1'b0;
    load_data4 = 8'h00; pc4 = 8'h00;

    // Reset with load_start held high
    edge_sample();
    edge_sample();
    chk("rst_run",   {7'd0, run},        8'd0);
    chk("rst_instr", instruction,        8'h00);
    chk("rst_len",   prog_len,           8'd0);
    chk("rst_ready", {7'd0, load_ready}, 8'd0);

    // Load five words, then run
    @(negedge clk); rst_n = 1'b1; load_start = 1'b1;
    edge_sample();
    chk("load_ready", {7'd0, load_ready}, 8'd1);
    chk("load_run",   {7'd0, run},        8'd0);
    @(negedge clk); load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1;
      load_data  = vecs[i].instr;
      edge_sample();
      @(negedge clk);
    end
    load_valid = 1'b0; load_done = 1'b1;
    edge_sample();
    @(negedge clk); load_done = 1'b0;
    chk("run_high", {7'd0, run}, 8'd1);
    chk("len5",     prog_len,    8'd5);
    chk("first_nop", instruction, 8'h00);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk); pc = vecs[i].pc;
      edge_sample();
      chk($sformatf("fetch_pc%02h", vecs[i].pc), instruction, vecs[i].instr);
      chk("fetch_run", {7'd0, run}, 8'd1);
    end

    // load_start and load_done together in RUN
    @(negedge clk); load_start = 1'b1; load_done = 1'b1;
    edge_sample();
    chk("sim_run",   {7'd0, run},        8'd0);
    chk("sim_instr", instruction,        8'h00);
    chk("sim_ready", {7'd0, load_ready}, 8'd1);
    chk("sim_len",   prog_len,           8'd0);

    // Beat and load_done together
    @(negedge clk); load_start = 1'b0; load_done = 1'b0; load_valid = 1'b1; load_data = 8'hAA;
    edge_sample();
    @(negedge clk); load_data = 8'hBB; load_done = 1'b1;
    edge_sample();
    @(negedge clk); load_valid = 1'b0; load_done = 1'b0;
    chk("bd_run", {7'd0, run}, 8'd1);
    chk("bd_len", prog_len,    8'd2);
    pc = 8'd1;
    edge_sample();
    chk("bd_pc1", instruction, 8'hBB);
    @(negedge clk); pc = 8'd0;
    edge_sample();
    chk("bd_pc0", instruction, 8'hAA);
    @(negedge clk); pc = 8'd2;
    edge_sample();
    chk("bd_pc2", instruction, 8'h00);

    // Full program store on the DEPTH=4 instance
    @(negedge clk); load_start4 = 1'b1;
    edge_sample();
    @(negedge clk); load_start4 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid4 = 1'b1;
      load_data4  = 8'hA1 + 8'(i);
      #1;
      chk($sformatf("full_ready%0d", i), {7'd0, load_ready4}, (i < 4) ? 8'd1 : 8'd0);
      edge_sample();
      @(negedge clk);
    end
    load_valid4 = 1'b0;
    chk("full_len", prog_len4, 8'd4);
    load_done4 = 1'b1;
    edge_sample();
    @(negedge clk); load_done4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc4 = 8'(i);
      edge_sample();
      chk($sformatf("full_pc%0d", i), instruction4, (i < 4) ? 8'hA1 + 8'(i) : 8'h00);
      @(negedge clk);
    end

`ifdef LOAD_CHECKSUM_EN
    load_start = 1'b1;
    edge_sample();
    chk("cks_clear0", checksum, 8'h00);
    @(negedge clk); load_start = 1'b0; load_valid = 1'b1; load_data = 8'hFF;
    edge_sample();
    @(negedge clk); load_data = 8'h02;
    edge_sample();
    @(negedge clk); load_valid = 1'b0;
    chk("cks_sum", checksum, 8'h01);
    load_start = 1'b1;
    edge_sample();
    chk("cks_clear", checksum, 8'h00);
    @(negedge clk); load_start = 1'b0;
`endif

    // Reset during a partial load loses it
    @(negedge clk); load_start = 1'b1;
    edge_sample();
    @(negedge clk); load_start = 1'b0; load_valid = 1'b1; load_data = 8'h33;
    edge_sample();
    chk("part_len", prog_len, 8'd1);
    @(negedge clk); load_valid = 1'b0; rst_n = 1'b0;
    edge_sample();
    chk("part_rst_len",   prog_len,           8'd0);
    chk("part_rst_ready", {7'd0, load_ready}, 8'd0);
    chk("part_rst_run",   {7'd0, run},        8'd0);
    @(negedge clk); rst_n = 1'b1; load_done = 1'b1;
    edge_sample();
    chk("idle_ignores_done", {7'd0, run}, 8'd0);
    @(negedge clk); load_done = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
